// File: rtl/sr_ff_scheduler.sv
// sr_ff_scheduler: round-robin set/clear scheduler that drives timed active-low
// S/R pulses into a bank of SR status flags and checks the resulting Q.
module sr_ff_scheduler #(
   parameter int N    = 8,
   parameter int HOLD = 1,
   parameter int IW   = (N > 2) ? $clog2(N) : 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ0,
   input  logic          CMD0,
   input  logic [IW-1:0] IDX0,
   output logic          ACK0,
   input  logic          REQ1,
   input  logic          CMD1,
   input  logic [IW-1:0] IDX1,
   output logic          ACK1,
   output logic [N-1:0]  S_N,
   output logic [N-1:0]  R_N,
   input  logic [N-1:0]  Q,
   output logic          BUSY,
   output logic          ERR
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

   state_t        state_r;
   state_t        state_nxt_s;
   logic          cmd_r;
   logic          gnt_r;
   logic          last_r;
   logic [IW-1:0] idx_r;
   logic [3:0]    hold_cnt_r;

   logic          any_req_s;
   logic          win_s;
   logic          sel_gnt_s;
   logic          sel_cmd_s;
   logic [IW-1:0] sel_idx_s;
   logic [N-1:0]  onehot_s;
   logic          oor_s;
   logic          q_bit_s;

   logic [N-1:0]  s_n_nxt_s;
   logic [N-1:0]  r_n_nxt_s;
   logic          ack0_nxt_s;
   logic          ack1_nxt_s;
   logic          err_nxt_s;
   logic          busy_nxt_s;

   // Round-robin pick; in IDLE the winner's command is used before it is latched
   always_comb begin
      any_req_s = REQ0 | REQ1;
      if (REQ0 && REQ1) begin
         win_s = ~last_r;
      end else if (REQ1) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
      if (state_r == ST_IDLE) begin
         sel_gnt_s = win_s;
         sel_cmd_s = win_s ? CMD1 : CMD0;
         sel_idx_s = win_s ? IDX1 : IDX0;
      end else begin
         sel_gnt_s = gnt_r;
         sel_cmd_s = cmd_r;
         sel_idx_s = idx_r;
      end
   end

   // Target decode: an out-of-range index matches no flop and so drives nothing
   always_comb begin
      onehot_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         onehot_s[i] = (sel_idx_s == IW'(i));
      end
      oor_s   = ~|onehot_s;
      q_bit_s = |(Q & onehot_s);
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_nxt_s = oor_s ? ST_RELEASE : ST_DRIVE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (hold_cnt_r == HOLD_LAST) begin
               state_nxt_s = ST_RELEASE;
            end else begin
               state_nxt_s = ST_DRIVE;
            end
         end
         ST_RELEASE: state_nxt_s = ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from the state being entered
   always_comb begin
      s_n_nxt_s  = {N{1'b1}};
      r_n_nxt_s  = {N{1'b1}};
      ack0_nxt_s = 1'b0;
      ack1_nxt_s = 1'b0;
      err_nxt_s  = 1'b0;
      busy_nxt_s = (state_nxt_s != ST_IDLE);
      case (state_nxt_s)
         ST_DRIVE: begin
            if (sel_cmd_s) begin
               s_n_nxt_s = ~onehot_s;
            end else begin
               r_n_nxt_s = ~onehot_s;
            end
         end
         ST_RELEASE: begin
            ack0_nxt_s = ~sel_gnt_s;
            ack1_nxt_s = sel_gnt_s;
            err_nxt_s  = oor_s | (q_bit_s != sel_cmd_s);
         end
         default: begin
            s_n_nxt_s = {N{1'b1}};
            r_n_nxt_s = {N{1'b1}};
         end
      endcase
   end

   // Output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         S_N  <= {N{1'b1}};
         R_N  <= {N{1'b1}};
         ACK0 <= 1'b0;
         ACK1 <= 1'b0;
         ERR  <= 1'b0;
         BUSY <= 1'b0;
      end else begin
         S_N  <= s_n_nxt_s;
         R_N  <= r_n_nxt_s;
         ACK0 <= ack0_nxt_s;
         ACK1 <= ack1_nxt_s;
         ERR  <= err_nxt_s;
         BUSY <= busy_nxt_s;
      end
   end

   // Command latch, round-robin history and pulse-width counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         cmd_r      <= 1'b0;
         idx_r      <= {IW{1'b0}};
         gnt_r      <= 1'b0;
         last_r     <= 1'b1;
         hold_cnt_r <= 4'd0;
      end else begin
         if ((state_r == ST_IDLE) && any_req_s) begin
            cmd_r  <= sel_cmd_s;
            idx_r  <= sel_idx_s;
            gnt_r  <= win_s;
            last_r <= win_s;
         end else begin
            cmd_r  <= cmd_r;
            idx_r  <= idx_r;
            gnt_r  <= gnt_r;
            last_r <= last_r;
         end
         if ((state_r == ST_DRIVE) && (state_nxt_s == ST_DRIVE)) begin
            hold_cnt_r <= hold_cnt_r + 4'd1;
         end else begin
            hold_cnt_r <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_sr_ff_scheduler.sv
// Scoreboard bench for sr_ff_scheduler: three instances (N=8/HOLD=1, N=8/HOLD=3,
// N=6/HOLD=1), each with a behavioural SR flop bank on its S_N/R_N lines.
module tb_sr_ff_scheduler;

   typedef struct {
      int         inst;
      logic       a0;
      logic       a1;
      logic       e;
      logic [7:0] ps;
      logic [7:0] pr;
      int         len;
      int         qi;
      logic       qv;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst  = 3'b111;
   logic [2:0] req0 = 3'b000;
   logic [2:0] cmd0 = 3'b000;
   logic [2:0] req1 = 3'b000;
   logic [2:0] cmd1 = 3'b000;
   logic [2:0] idx0 [3] = '{3'd0, 3'd0, 3'd0};
   logic [2:0] idx1 [3] = '{3'd0, 3'd0, 3'd0};
   logic [7:0] q    [3] = '{8'h00, 8'h00, 8'h00};
   logic [7:0] stuck[3] = '{8'h00, 8'h00, 8'h00};

   wire  [2:0] ack0, ack1, err, busy;
   wire  [7:0] sn [3];
   wire  [7:0] rn [3];
   wire  [5:0] sn_c, rn_c;
   assign sn[2] = {2'b11, sn_c};
   assign rn[2] = {2'b11, rn_c};

   sr_ff_scheduler #(.N(8), .HOLD(1)) dut_a (
      .CLK(clk), .RST(rst[0]),
      .REQ0(req0[0]), .CMD0(cmd0[0]), .IDX0(idx0[0]), .ACK0(ack0[0]),
      .REQ1(req1[0]), .CMD1(cmd1[0]), .IDX1(idx1[0]), .ACK1(ack1[0]),
      .S_N(sn[0]), .R_N(rn[0]), .Q(q[0]), .BUSY(busy[0]), .ERR(err[0]));

   sr_ff_scheduler #(.N(8), .HOLD(3)) dut_b (
      .CLK(clk), .RST(rst[1]),
      .REQ0(req0[1]), .CMD0(cmd0[1]), .IDX0(idx0[1]), .ACK0(ack0[1]),
      .REQ1(req1[1]), .CMD1(cmd1[1]), .IDX1(idx1[1]), .ACK1(ack1[1]),
      .S_N(sn[1]), .R_N(rn[1]), .Q(q[1]), .BUSY(busy[1]), .ERR(err[1]));

   sr_ff_scheduler #(.N(6), .HOLD(1)) dut_c (
      .CLK(clk), .RST(rst[2]),
      .REQ0(req0[2]), .CMD0(cmd0[2]), .IDX0(idx0[2]), .ACK0(ack0[2]),
      .REQ1(req1[2]), .CMD1(cmd1[2]), .IDX1(idx1[2]), .ACK1(ack1[2]),
      .S_N(sn_c), .R_N(rn_c), .Q(q[2][5:0]), .BUSY(busy[2]), .ERR(err[2]));

   // Flop bank model: a low S/R line takes effect mid-cycle; stuck bits read 0
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         q[i] <= ((q[i] | ~sn[i]) & rn[i]) & ~stuck[i];
      end
   end

   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t sb_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic chk_idle(input string tag, input int i);
      chk({tag, "_s_n"}, {24'd0, sn[i]}, 32'h0000_00FF);
      chk({tag, "_r_n"}, {24'd0, rn[i]}, 32'h0000_00FF);
      chk({tag, "_ack_err_busy"}, {28'd0, ack0[i], ack1[i], err[i], busy[i]}, 32'd0);
   endtask

   task automatic push(input int inst, input logic a0, input logic a1, input logic e,
                       input logic [7:0] ps, input logic [7:0] pr, input int len,
                       input int qi, input logic qv);
      exp_t x;
      x.inst = inst; x.a0 = a0; x.a1 = a1; x.e = e;
      x.ps = ps; x.pr = pr; x.len = len; x.qi = qi; x.qv = qv;
      sb_q.push_back(x);
   endtask

   task automatic wait_ack(input int i, input bit which, input int budget, output int lat);
      lat = 0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if ((which ? ack1[i] : ack0[i]) === 1'b1) begin
            lat = c;
            break;
         end
      end
      if (lat == 0) begin
         n_chk++;
         $display("FAIL ack_timeout: inst %0d requester %0d got no ACK, required within %0d cycles",
                  i, which, budget);
      end
   endtask

   task automatic wait_drive(input int i, input int budget);
      bit seen = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (sn[i] !== 8'hFF || rn[i] !== 8'hFF) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_chk++;
         $display("FAIL drive_timeout: inst %0d got no pulse, required within %0d cycles", i, budget);
      end
   endtask

   // Monitor: captures each pulse and checks it against the scoreboard on ACK
   logic [7:0] obs_s [3] = '{8'hFF, 8'hFF, 8'hFF};
   logic [7:0] obs_r [3] = '{8'hFF, 8'hFF, 8'hFF};
   int         obs_len [3] = '{0, 0, 0};
   logic       bad [3] = '{1'b0, 1'b0, 1'b0};

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (busy[i] !== 1'b1) begin
               obs_s[i] = 8'hFF; obs_r[i] = 8'hFF; obs_len[i] = 0; bad[i] = 1'b0;
            end
            if (sn[i] !== 8'hFF || rn[i] !== 8'hFF) begin
               obs_s[i] = sn[i];
               obs_r[i] = rn[i];
               obs_len[i]++;
               if ($countones(~sn[i] | ~rn[i]) > 1 || (~sn[i] & ~rn[i]) != 8'h00) bad[i] = 1'b1;
            end
            if (ack0[i] === 1'b1 || ack1[i] === 1'b1) begin
               chk("sb_expecting_ack", {31'd0, sb_q.size() > 0}, 32'd1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  chk("mon_instance", i, e.inst);
                  chk("mon_ack0", {31'd0, ack0[i]}, {31'd0, e.a0});
                  chk("mon_ack1", {31'd0, ack1[i]}, {31'd0, e.a1});
                  chk("mon_err", {31'd0, err[i]}, {31'd0, e.e});
                  chk("mon_busy", {31'd0, busy[i]}, 32'd1);
                  chk("mon_s_n_pulse", {24'd0, obs_s[i]}, {24'd0, e.ps});
                  chk("mon_r_n_pulse", {24'd0, obs_r[i]}, {24'd0, e.pr});
                  chk("mon_pulse_len", obs_len[i], e.len);
                  chk("mon_legal_lines", {31'd0, bad[i]}, 32'd0);
                  if (e.qi >= 0) chk("mon_q_bit", {31'd0, q[i][e.qi]}, {31'd0, e.qv});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int lat;
      int lat1;
      logic seen;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) chk_idle($sformatf("reset_inst%0d", i), i);
      rst = 3'b000;
      @(negedge clk);

      // A: single set on idx 3
      push(0, 1'b1, 1'b0, 1'b0, 8'hF7, 8'hFF, 1, 3, 1'b1);
      cmd0[0] = 1'b1; idx0[0] = 3'd3; req0[0] = 1'b1;
      wait_ack(0, 1'b0, 10, lat);
      req0[0] = 1'b0;
      chk("a_set_latency", lat, 2);

      // A: reset in the middle of a pulse aborts it without ACK
      cmd0[0] = 1'b1; idx0[0] = 3'd4; req0[0] = 1'b1;
      wait_drive(0, 10);
      chk("a_abort_pulse_seen", {24'd0, sn[0]}, 32'h0000_00EF);
      rst[0] = 1'b1; req0[0] = 1'b0;
      @(negedge clk);
      chk_idle("a_abort_edge1", 0);
      @(negedge clk);
      chk_idle("a_abort_edge2", 0);
      rst[0] = 1'b0;
      @(negedge clk);

      // A: contention on idx 2, requester 0 granted first after reset
      push(0, 1'b1, 1'b0, 1'b0, 8'hFB, 8'hFF, 1, 2, 1'b1);
      push(0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFB, 1, 2, 1'b0);
      cmd0[0] = 1'b1; idx0[0] = 3'd2; cmd1[0] = 1'b0; idx1[0] = 3'd2;
      req0[0] = 1'b1; req1[0] = 1'b1;
      wait_ack(0, 1'b0, 10, lat);
      req0[0] = 1'b0;
      chk("a_tie_ack0_latency", lat, 2);
      wait_ack(0, 1'b1, 10, lat1);
      req1[0] = 1'b0;
      chk("a_tie_ack_gap", lat1, 3);
      @(negedge clk);
      chk("a_tie_final_q2", {31'd0, q[0][2]}, 32'd0);

      // A: stuck-at-0 flop makes the set fail
      stuck[0] = 8'h20;
      push(0, 1'b1, 1'b0, 1'b1, 8'hDF, 8'hFF, 1, 5, 1'b0);
      cmd0[0] = 1'b1; idx0[0] = 3'd5; req0[0] = 1'b1;
      wait_ack(0, 1'b0, 10, lat);
      req0[0] = 1'b0;
      @(negedge clk);

      // B (HOLD=3): set idx 7 by requester 1, then clear it by requester 0
      push(1, 1'b0, 1'b1, 1'b0, 8'h7F, 8'hFF, 3, 7, 1'b1);
      cmd1[1] = 1'b1; idx1[1] = 3'd7; req1[1] = 1'b1;
      wait_ack(1, 1'b1, 12, lat);
      req1[1] = 1'b0;
      chk("b_set_latency", lat, 4);
      @(negedge clk);
      push(1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h7F, 3, 7, 1'b0);
      cmd0[1] = 1'b0; idx0[1] = 3'd7; req0[1] = 1'b1;
      wait_ack(1, 1'b0, 12, lat);
      req0[1] = 1'b0;
      chk("b_clear_latency", lat, 4);
      @(negedge clk);

      // B: reset during DRIVE, no ACK afterwards
      cmd1[1] = 1'b1; idx1[1] = 3'd1; req1[1] = 1'b1;
      wait_drive(1, 10);
      rst[1] = 1'b1; req1[1] = 1'b0;
      @(negedge clk);
      chk_idle("b_abort_edge1", 1);
      @(negedge clk);
      rst[1] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | ack0[1] | ack1[1] | err[1];
      end
      chk("b_abort_no_ack", {31'd0, seen}, 32'd0);

      // C (N=6): out-of-range index, then an in-range set on the top flop
      push(2, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 0, -1, 1'b0);
      cmd1[2] = 1'b1; idx1[2] = 3'd6; req1[2] = 1'b1;
      wait_ack(2, 1'b1, 10, lat);
      req1[2] = 1'b0;
      chk("c_oor_latency", lat, 1);
      @(negedge clk);
      push(2, 1'b1, 1'b0, 1'b0, 8'hDF, 8'hFF, 1, 5, 1'b1);
      cmd0[2] = 1'b1; idx0[2] = 3'd5; req0[2] = 1'b1;
      wait_ack(2, 1'b0, 10, lat);
      req0[2] = 1'b0;
      chk("c_set_latency", lat, 2);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
